rw_mode_arbiter: RTL
====================

RW_MODE_ARBITER -- requirements
Module: rw_mode_arbiter

Interface
REQ-001 SHALL have parameter TURN_RD2WR, default 2: idle cycles inserted on a read-to-write switch (range 1..15).
REQ-002 SHALL have parameter TURN_WR2RD, default 4: idle cycles inserted on a write-to-read switch (range 1..15).
REQ-003 SHALL have parameter WR_STARVE_MAX, default 32: cycles of READ residency with writes pending that force a write switch.
REQ-004 SHALL have parameter MIN_WR_BURST, default 4: minimum write pops per WRITE residency before a low-watermark exit.
REQ-005 SHALL have ports: clk  in  1  clock; rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have ports: hwm  in  1  write-count high watermark; lwm  in  1  write-count low watermark.
REQ-007 SHALL have ports: rd_pending  in  1  read queue non-empty; wr_pending  in  1  write queue non-empty; sel_ready  in  1  downstream accepts a request this cycle.
REQ-008 SHALL have ports: rd_pop  out  1  read dequeue strobe; wr_pop  out  1  write dequeue strobe; out_type  out  1  issued type (READ=1, WRITE=0).
REQ-009 SHALL have ports: mode_write  out  1  high in WRITE state; turnaround  out  1  high in either turnaround state.

Function
REQ-010 SHALL implement four states: READ, RD2WR, WRITE, WR2RD.
REQ-011 SHALL, in READ, assert rd_pop = rd_pending & sel_ready combinationally, with wr_pop=0.
REQ-012 SHALL, in WRITE, assert wr_pop = wr_pending & sel_ready combinationally, with rd_pop=0.
REQ-013 SHALL never assert rd_pop and wr_pop in the same cycle, and SHALL assert neither in RD2WR or WR2RD.
REQ-014 SHALL drive out_type=WRITE when wr_pop=1, and out_type=READ otherwise.
REQ-015 SHALL leave READ for RD2WR when hwm=1, or when (rd_pending=0 & wr_pending=1), or when (starve_cnt==WR_STARVE_MAX & wr_pending=1).
REQ-016 SHALL stay in RD2WR for exactly TURN_RD2WR cycles, then enter WRITE.
REQ-017 SHALL stay in WR2RD for exactly TURN_WR2RD cycles, then enter READ.
REQ-018 SHALL leave WRITE for WR2RD when rd_pending=1 and either (lwm=1 & burst_cnt>=MIN_WR_BURST) or wr_pending=0.
REQ-019 SHALL keep WRITE while hwm=1, regardless of rd_pending.
REQ-020 SHALL keep the current state when both queues are empty.
REQ-021 SHALL, in READ, increment starve_cnt each cycle that wr_pending=1, saturate it at WR_STARVE_MAX, and clear it when rd_pop fires with wr_pending=0 or on entry to RD2WR.
REQ-022 SHALL increment burst_cnt on each wr_pop, saturate it at MIN_WR_BURST, and clear it on entry to WRITE.
REQ-023 SHALL size counters with $clog2(max+1) bits, and SHALL keep turnaround counters 4 bits wide.
REQ-024 SHALL evaluate state transitions on the registered state, so a pop in the exit cycle of READ/WRITE is still issued.

Reset
REQ-025 SHALL, while rst_n=0 at a clk edge, set state=READ, starve_cnt=0, burst_cnt=0 and turnaround counter=0.
REQ-026 SHALL hold outputs mode_write=0, turnaround=0, wr_pop=0, rd_pop=0 and out_type=READ in the cycle after reset, with rd_pending=0.
REQ-027 SHALL, when reset is asserted mid-turnaround or mid-WRITE, abandon the sequence and return to READ with no residual pop.

Structure
REQ-028 SHALL take the READ/WRITE type constants and the state enum (rw_state_t) from shared package bank_sched_pkg.
REQ-029 SHALL implement both turnaround waits in one sub-module turn_timer (load value, start, done), instantiated once.

Verification
REQ-030 SHALL verify: rd_pending=1 and wr_pending=1, hwm rising at cycle 10 -> rd_pop stops at cycle 11, 2 idle cycles, wr_pop at cycle 13 with out_type=0.
REQ-031 SHALL verify: in WRITE with lwm=1, rd_pending=1 after 2 wr_pops -> remains WRITE until the 4th wr_pop, then 4 turnaround cycles, then rd_pop.
REQ-032 SHALL verify: rd_pending=1, wr_pending=1, hwm=0 held constantly -> switch to RD2WR after exactly 32 READ cycles.
REQ-033 SHALL verify: sel_ready=0 in WRITE -> no pops and burst_cnt frozen; sel_ready=1 resumes wr_pop the same cycle.
REQ-034 SHALL verify: rst_n=0 during the 2nd WR2RD cycle -> next cycle is READ, turnaround=0, and no pop while rd_pending=0.
REQ-035 SHALL verify: random pending/ready stimulus for 10k cycles -> assertion that rd_pop&wr_pop is never 1 and that no pop occurs when turnaround=1.

Source files
------------

// File: rtl/bank_sched_pkg.sv
// Shared scheduler types: read/write arbitration state and issued-request type encoding.
// Latency: n/a (types only).
// Backpressure: n/a.
package bank_sched_pkg;

    typedef enum logic [1:0] {
        ST_READ  = 2'd0,
        ST_RD2WR = 2'd1,
        ST_WRITE = 2'd2,
        ST_WR2RD = 2'd3
    } rw_state_t;

    localparam logic TYPE_READ  = 1'b1;
    localparam logic TYPE_WRITE = 1'b0;

    localparam int TURN_CNT_W = 4;

    function automatic logic is_turn_state(input rw_state_t s);
        return (s == ST_RD2WR) || (s == ST_WR2RD);
    endfunction

endpackage

// File: rtl/turn_timer.sv
// Counts the idle cycles of a bus turnaround; done is high in the final idle cycle.
// Latency: done asserts load_val cycles after the start edge (load_val >= 1).
// Backpressure: none; the wait always runs to completion unless reset.
module turn_timer
    import bank_sched_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [TURN_CNT_W-1:0] load_val,
    output logic                  done
);

    logic [TURN_CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - TURN_CNT_W'(1);
        end
    end

    assign done = (cnt == TURN_CNT_W'(1));

endmodule

// File: rtl/rw_mode_arbiter.sv
// Read/write mode arbiter: drains one queue type at a time with turnaround gaps between modes.
// Latency: pops are combinational from pending & sel_ready; mode changes take effect next cycle.
// Backpressure: sel_ready=0 suppresses pops and freezes the write burst count.
module rw_mode_arbiter
    import bank_sched_pkg::*;
#(
    parameter int TURN_RD2WR    = 2,
    parameter int TURN_WR2RD    = 4,
    parameter int WR_STARVE_MAX = 32,
    parameter int MIN_WR_BURST  = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hwm,
    input  logic lwm,
    input  logic rd_pending,
    input  logic wr_pending,
    input  logic sel_ready,
    output logic rd_pop,
    output logic wr_pop,
    output logic out_type,
    output logic mode_write,
    output logic turnaround
);

    localparam int SW = $clog2(WR_STARVE_MAX + 1);
    localparam int BW = $clog2(MIN_WR_BURST + 1);

    localparam logic [SW-1:0]         STARVE_MAX_C = SW'(WR_STARVE_MAX);
    localparam logic [BW-1:0]         BURST_MIN_C  = BW'(MIN_WR_BURST);
    localparam logic [TURN_CNT_W-1:0] LOAD_RD2WR   = TURN_CNT_W'(TURN_RD2WR);
    localparam logic [TURN_CNT_W-1:0] LOAD_WR2RD   = TURN_CNT_W'(TURN_WR2RD);

    rw_state_t             state;
    rw_state_t             state_nxt;
    logic [SW-1:0]         starve_cnt;
    logic [BW-1:0]         burst_cnt;
    logic                  tmr_start;
    logic [TURN_CNT_W-1:0] tmr_load;
    logic                  tmr_done;
    logic                  any_pending;
    logic                  rd_exit;
    logic                  wr_exit;

    assign any_pending = rd_pending | wr_pending;

    // hwm with both queues empty is treated as stale and never forces a switch
    assign rd_exit = any_pending &
                     (hwm | (!rd_pending & wr_pending) |
                      ((starve_cnt == STARVE_MAX_C) & wr_pending));

    // a high watermark pins WRITE even when reads are waiting
    assign wr_exit = !hwm & rd_pending &
                     ((lwm & (burst_cnt >= BURST_MIN_C)) | !wr_pending);

    always_comb begin
        state_nxt = state;
        rd_pop    = 1'b0;
        wr_pop    = 1'b0;
        tmr_start = 1'b0;
        tmr_load  = '0;
        unique case (state)
            ST_READ: begin
                rd_pop = rd_pending & sel_ready;
                if (rd_exit) begin
                    state_nxt = ST_RD2WR;
                    tmr_start = 1'b1;
                    tmr_load  = LOAD_RD2WR;
                end
            end
            ST_RD2WR: begin
                if (tmr_done) begin
                    state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                wr_pop = wr_pending & sel_ready;
                if (wr_exit) begin
                    state_nxt = ST_WR2RD;
                    tmr_start = 1'b1;
                    tmr_load  = LOAD_WR2RD;
                end
            end
            ST_WR2RD: begin
                if (tmr_done) begin
                    state_nxt = ST_READ;
                end
            end
            default: begin
                state_nxt = ST_READ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_READ;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (state == ST_READ) begin
            if (state_nxt == ST_RD2WR) begin
                starve_cnt <= '0;
            end else if (rd_pop && !wr_pending) begin
                starve_cnt <= '0;
            end else if (wr_pending && (starve_cnt != STARVE_MAX_C)) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            burst_cnt <= '0;
        end else if ((state_nxt == ST_WRITE) && (state != ST_WRITE)) begin
            burst_cnt <= '0;
        end else if (wr_pop && (burst_cnt != BURST_MIN_C)) begin
            burst_cnt <= burst_cnt + BW'(1);
        end
    end

    turn_timer u_turn_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (tmr_start),
        .load_val (tmr_load),
        .done     (tmr_done)
    );

    assign out_type   = wr_pop ? TYPE_WRITE : TYPE_READ;
    assign mode_write = (state == ST_WRITE);
    assign turnaround = is_turn_state(state);

endmodule
